// File: rtl/aqed_mon_pkg.sv
// Shared types and defaults for the A-QED response monitor.
package aqed_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2,
    FAIL  = 2'd3
  } mon_state_t;

  localparam int DEF_RESP_BOUND = 16;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_TS_W       = 8;

  // Age is a modular difference, so callers pass it zero-extended.
  function automatic logic age_over(input logic [31:0] age, input logic [31:0] bound);
    return age > bound;
  endfunction

endpackage

// File: rtl/aqed_ts_fifo.sv
// Circular timestamp FIFO tracking outstanding writes; caller guarantees legal push/pop.
module aqed_ts_fifo #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [TS_W-1:0]          din,
  output logic [TS_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign count = cnt;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/aqed_resp_monitor.sv
// Response-bound and functional-consistency monitor for the A-QED harness.
// Optional AQED_MAX_LAT_EN adds a max_lat output tracking the worst popped age.
module aqed_resp_monitor
  import aqed_mon_pkg::*;
#(
  parameter int RESP_BOUND = DEF_RESP_BOUND,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TS_W       = DEF_TS_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    flush,
  input  logic                    wen_in,
  input  logic                    ren_in,
  input  logic                    valid_out,
  input  logic                    qed_done,
  input  logic                    qed_check,
  output logic                    rb_fail,
  output logic                    fc_fail,
  output logic                    ovf_err,
  output logic                    unf_err,
  output logic                    check_done,
  output logic [$clog2(DEPTH):0]  outstanding
`ifdef AQED_MAX_LAT_EN
  ,
  output logic [TS_W-1:0]         max_lat
`endif
);

  mon_state_t      state;
  logic [TS_W-1:0] ts, head_ts, age;
  logic            full, empty;
  logic            push, pop, pop_ok, push_ok, unf_ev, ovf_ev, rb_ev, fl;
  logic            fc_good, fc_bad, err_ev;

  assign push    = clk_en & wen_in & ~flush;
  assign pop     = clk_en & ren_in & valid_out & ~flush;
  assign fl      = clk_en & flush;
  assign pop_ok  = pop & ~empty;
  assign unf_ev  = pop & empty;
  // A pop at full frees the slot this cycle, so the push is still legal.
  assign ovf_ev  = push & full & ~pop_ok;
  assign push_ok = push & ~ovf_ev;
  assign age     = ts - head_ts;
  assign rb_ev   = clk_en & ~empty & age_over(32'(age), 32'(RESP_BOUND));
  assign fc_good = clk_en & qed_done & qed_check & (state == ARMED);
  assign fc_bad  = clk_en & qed_done & ~qed_check & ((state == ARMED) || (state == DONE));
  assign err_ev  = rb_ev | ovf_ev | unf_ev;

  aqed_ts_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop_ok),
    .flush (fl),
    .din   (ts),
    .dout  (head_ts),
    .count (outstanding),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else if (clk_en) ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rb_fail    <= 1'b0;
      fc_fail    <= 1'b0;
      ovf_err    <= 1'b0;
      unf_err    <= 1'b0;
      check_done <= 1'b0;
    end else if (clk_en) begin
      if (rb_ev)            rb_fail    <= 1'b1;
      if (ovf_ev)           ovf_err    <= 1'b1;
      if (unf_ev)           unf_err    <= 1'b1;
      if (fc_bad)           fc_fail    <= 1'b1;
      if (fc_good | fc_bad) check_done <= 1'b1;
      if (state != FAIL) begin
        if (err_ev | fc_bad) state <= FAIL;
        else if (fl)         state <= IDLE;
        else begin
          case (state)
            IDLE:    if (push)    state <= ARMED;
            ARMED:   if (fc_good) state <= DONE;
            default: state <= state;
          endcase
        end
      end
    end
  end

`ifdef AQED_MAX_LAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_lat <= '0;
    else if (pop_ok && (age > max_lat)) max_lat <= age;
  end
`endif

endmodule
